// File: rtl/output_wrapper_n.sv
// Output stage between the IMC array and the shared output bus: buffers one frame of
// NUM_WORDS words, arbitrates for the bus and streams the words out with per-word accept.
module output_wrapper_n #(
    parameter int DATA_WIDTH    = 16,
    parameter int NUM_WORDS     = 4,
    parameter int CAPTURE_MODE  = 1,
    parameter int GRANT_TIMEOUT = 0,
    localparam int IDXW         = $clog2(NUM_WORDS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            ready,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] dataIn,
    input  logic                            startTransmit,
    input  logic                            grant,
    input  logic                            outAccepted,
    output logic [DATA_WIDTH-1:0]           dataOut,
    output logic                            outAvail,
    output logic                            request,
    output logic                            outReady,
    output logic [IDXW-1:0]                 wordIdx,
    output logic                            timeout
);

    localparam int TW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;

    localparam logic [2:0] StWait    = 3'd0;
    localparam logic [2:0] StCapture = 3'd1;
    localparam logic [2:0] StAvail   = 3'd2;
    localparam logic [2:0] StRequest = 3'd3;
    localparam logic [2:0] StXmit    = 3'd4;

    localparam logic [IDXW-1:0] LastIdx = IDXW'(NUM_WORDS - 1);

    logic [2:0]            state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  timeout_q, timeout_d;
    logic [DATA_WIDTH-1:0] data_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] data_d [NUM_WORDS];
    logic [DATA_WIDTH-1:0] word_in [NUM_WORDS];

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_unpack
        assign word_in[g] = dataIn[g*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        data_d    = data_q;
        case (state_q)
            StWait: begin
                if (ready) begin
                    if (CAPTURE_MODE == 1) begin
                        state_d = StCapture;
                        idx_d   = '0;
                    end else begin
                        data_d  = word_in;
                        state_d = StAvail;
                    end
                end
            end
            StCapture: begin
                data_d[idx_q] = word_in[idx_q];
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StAvail;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            StAvail: begin
                if (startTransmit) begin
                    state_d = StRequest;
                    timer_d = '0;
                end
            end
            StRequest: begin
                if (grant) begin
                    state_d = StXmit;
                end else if (GRANT_TIMEOUT > 0 && timer_q == TW'(GRANT_TIMEOUT - 1)) begin
                    // Give up but keep the frame and resume point for the next attempt.
                    timeout_d = 1'b1;
                    state_d   = StAvail;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StXmit: begin
                if (outAccepted && idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StWait;
                end else begin
                    if (outAccepted) begin
                        idx_d = idx_q + IDXW'(1);
                    end
                    if (!grant) begin
                        state_d = StRequest;
                        timer_d = '0;
                    end
                end
            end
            default: begin
                state_d = StWait;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StWait;
            idx_q     <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
            data_q    <= data_d;
        end
    end

    assign outAvail = (state_q == StAvail);
    assign request  = (state_q == StRequest) || (state_q == StXmit);
    assign outReady = (state_q == StXmit);
    assign dataOut  = outReady ? data_q[idx_q] : '0;
    assign wordIdx  = idx_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_output_wrapper_n.sv
// Directed bench for output_wrapper_n: a capture-mode-1 instance with grant timeout and a
// snapshot-mode instance with three words per frame.
module tb_output_wrapper_n;

    logic        clk;
    logic        rst;

    logic        ready_a, st_a, grant_a, acc_a;
    logic [63:0] data_a;
    logic [15:0] dout_a;
    logic        avail_a, req_a, ordy_a, to_a;
    logic [1:0]  idx_a;

    logic        ready_b, st_b, grant_b, acc_b;
    logic [47:0] data_b;
    logic [15:0] dout_b;
    logic        avail_b, req_b, ordy_b, to_b;
    logic [1:0]  idx_b;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] ws [4];

    output_wrapper_n #(
        .DATA_WIDTH(16), .NUM_WORDS(4), .CAPTURE_MODE(1), .GRANT_TIMEOUT(5)
    ) u_dut_a (
        .clk(clk), .rst(rst), .ready(ready_a), .dataIn(data_a), .startTransmit(st_a),
        .grant(grant_a), .outAccepted(acc_a), .dataOut(dout_a), .outAvail(avail_a),
        .request(req_a), .outReady(ordy_a), .wordIdx(idx_a), .timeout(to_a)
    );

    output_wrapper_n #(
        .DATA_WIDTH(16), .NUM_WORDS(3), .CAPTURE_MODE(0), .GRANT_TIMEOUT(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .ready(ready_b), .dataIn(data_b), .startTransmit(st_b),
        .grant(grant_b), .outAccepted(acc_b), .dataOut(dout_b), .outAvail(avail_b),
        .request(req_b), .outReady(ordy_b), .wordIdx(idx_b), .timeout(to_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic av, input logic rq, input logic rd,
                         input logic [15:0] d, input logic [1:0] ix, input logic to);
        chk({tag, ".outAvail"}, 32'(avail_a), 32'(av));
        chk({tag, ".request"},  32'(req_a),   32'(rq));
        chk({tag, ".outReady"}, 32'(ordy_a),  32'(rd));
        chk({tag, ".dataOut"},  32'(dout_a),  32'(d));
        chk({tag, ".wordIdx"},  32'(idx_a),   32'(ix));
        chk({tag, ".timeout"},  32'(to_a),    32'(to));
    endtask

    task automatic chk_b(input string tag, input logic av, input logic rq, input logic rd,
                         input logic [15:0] d, input logic [1:0] ix);
        chk({tag, ".outAvail"}, 32'(avail_b), 32'(av));
        chk({tag, ".request"},  32'(req_b),   32'(rq));
        chk({tag, ".outReady"}, 32'(ordy_b),  32'(rd));
        chk({tag, ".dataOut"},  32'(dout_b),  32'(d));
        chk({tag, ".wordIdx"},  32'(idx_b),   32'(ix));
        chk({tag, ".timeout"},  32'(to_b),    32'(0));
    endtask

    // Present a frame to instance A and run it through CAPTURE into AVAIL.
    task automatic load_a(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2, input logic [15:0] w3);
        ws[0]   = w0;
        ws[1]   = w1;
        ws[2]   = w2;
        ws[3]   = w3;
        data_a  = {w3, w2, w1, w0};
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        ready_a = 1'b0; st_a = 1'b0; grant_a = 1'b0; acc_a = 1'b0; data_a = '0;
        ready_b = 1'b0; st_b = 1'b0; grant_b = 1'b0; acc_b = 1'b0; data_b = '0;
        tick();
        tick();
        rst = 1'b0;
        chk_a("reset_a", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        chk_b("reset_b", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0);

        // Mode 1 capture: one word per cycle, outAvail NUM_WORDS+1 cycles after ready.
        ws[0] = 16'h00A1; ws[1] = 16'h00B2; ws[2] = 16'h00C3; ws[3] = 16'h00D4;
        data_a  = {ws[3], ws[2], ws[1], ws[0]};
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1.cap_avail", 32'(avail_a), 32'(0));
            chk("t1.cap_idx", 32'(idx_a), 32'(i));
            tick();
        end
        chk_a("t1.avail", 1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        st_a = 1'b1; grant_a = 1'b1; acc_a = 1'b1;
        tick();
        st_a = 1'b0;
        chk_a("t1.request", 1'b0, 1'b1, 1'b0, 16'h0, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_a("t1.xmit", 1'b0, 1'b1, 1'b1, ws[i], 2'(i), 1'b0);
        end
        tick();
        chk_a("t1.wait", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        grant_a = 1'b0; acc_a = 1'b0;
        tick();
        chk_a("t1.wait_hold", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);

        // Mode 0 snapshot; later dataIn changes and ready held in AVAIL must be ignored.
        data_b  = {16'h3333, 16'h2222, 16'h1111};
        ready_b = 1'b1;
        tick();
        chk_b("t2.avail", 1'b1, 1'b0, 1'b0, 16'h0, 2'd0);
        data_b = {16'hFFFF, 16'hFFFF, 16'hFFFF};
        tick();
        chk_b("t2.avail_hold", 1'b1, 1'b0, 1'b0, 16'h0, 2'd0);
        ready_b = 1'b0;
        st_b = 1'b1; grant_b = 1'b1; acc_b = 1'b1;
        tick();
        st_b = 1'b0;
        chk_b("t2.request", 1'b0, 1'b1, 1'b0, 16'h0, 2'd0);
        tick();
        chk_b("t2.w0", 1'b0, 1'b1, 1'b1, 16'h1111, 2'd0);
        tick();
        chk_b("t2.w1", 1'b0, 1'b1, 1'b1, 16'h2222, 2'd1);
        tick();
        chk_b("t2.w2", 1'b0, 1'b1, 1'b1, 16'h3333, 2'd2);
        tick();
        chk_b("t2.wait", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0);
        grant_b = 1'b0; acc_b = 1'b0;

        // Toggled accept: each word held until accepted.
        load_a(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        chk_a("t3.avail", 1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        st_a = 1'b1; grant_a = 1'b1; acc_a = 1'b0;
        tick();
        st_a = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk_a("t3.word", 1'b0, 1'b1, 1'b1, ws[k], 2'(k), 1'b0);
            acc_a = 1'b0;
            tick();
            chk_a("t3.held", 1'b0, 1'b1, 1'b1, ws[k], 2'(k), 1'b0);
            acc_a = 1'b1;
            tick();
        end
        chk_a("t3.wait", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        acc_a = 1'b0; grant_a = 1'b0;

        // Grant lost at wordIdx 2 without accept, then resumed.
        load_a(16'h5501, 16'h5502, 16'h5503, 16'h5504);
        st_a = 1'b1; grant_a = 1'b1; acc_a = 1'b1;
        tick();
        st_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("t4.xmit", 1'b0, 1'b1, 1'b1, ws[i], 2'(i), 1'b0);
        end
        grant_a = 1'b0; acc_a = 1'b0;
        tick();
        chk_a("t4.lost", 1'b0, 1'b1, 1'b0, 16'h0, 2'd2, 1'b0);
        tick();
        chk_a("t4.lost2", 1'b0, 1'b1, 1'b0, 16'h0, 2'd2, 1'b0);
        grant_a = 1'b1; acc_a = 1'b1;
        tick();
        chk_a("t4.resume2", 1'b0, 1'b1, 1'b1, 16'h5503, 2'd2, 1'b0);
        tick();
        chk_a("t4.resume3", 1'b0, 1'b1, 1'b1, 16'h5504, 2'd3, 1'b0);
        tick();
        chk_a("t4.wait", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);

        // Accept and grant loss in the same cycle, mid-frame and on the last word.
        load_a(16'h6601, 16'h6602, 16'h6603, 16'h6604);
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        tick();
        chk_a("t4b.w0", 1'b0, 1'b1, 1'b1, 16'h6601, 2'd0, 1'b0);
        grant_a = 1'b0;
        tick();
        chk_a("t4b.req", 1'b0, 1'b1, 1'b0, 16'h0, 2'd1, 1'b0);
        grant_a = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_a("t4b.xmit", 1'b0, 1'b1, 1'b1, ws[i], 2'(i), 1'b0);
        end
        grant_a = 1'b0;
        tick();
        chk_a("t4b.wait", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        acc_a = 1'b0;

        // Grant timeout after 5 REQUEST cycles, then retry.
        load_a(16'h7701, 16'h7702, 16'h7703, 16'h7704);
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_a("t5.req", 1'b0, 1'b1, 1'b0, 16'h0, 2'd0, 1'b0);
            tick();
        end
        chk_a("t5.timeout", 1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b1);
        tick();
        chk_a("t5.pulse_end", 1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        chk_a("t5.retry", 1'b0, 1'b1, 1'b0, 16'h0, 2'd0, 1'b0);

        // Reset during XMIT at wordIdx 2, then a fresh frame.
        grant_a = 1'b1; acc_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("t6.xmit", 1'b0, 1'b1, 1'b1, ws[i], 2'(i), 1'b0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; grant_a = 1'b0; acc_a = 1'b0;
        chk_a("t6.reset", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        tick();
        chk_a("t6.idle", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        load_a(16'h8801, 16'h8802, 16'h8803, 16'h8804);
        chk_a("t6.avail", 1'b1, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);
        st_a = 1'b1; grant_a = 1'b1; acc_a = 1'b1;
        tick();
        st_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_a("t6.fresh", 1'b0, 1'b1, 1'b1, ws[i], 2'(i), 1'b0);
        end
        tick();
        chk_a("t6.wait", 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
